// File: rtl/checkbits_monitor_pkg.sv
// Shared types and default codes for the checkbits pass/fail monitor.
// The FSM encoding is visible on the debug state port, so its values are fixed.
package checkbits_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ALIVE = 2'd1,
        RUNNING    = 2'd2,
        DONE       = 2'd3
    } state_t;

    // One-hot verdict; all zero until the run ends.
    typedef struct packed {
        logic pass;
        logic fail;
        logic unknown;
        logic timeout;
    } verdict_t;

    localparam int          DEF_WIDTH          = 16;
    localparam logic [15:0] DEF_ALIVE_CODE     = 16'h0ffe;
    localparam logic [15:0] DEF_PASS_CODE      = 16'h00d5;
    localparam logic [15:0] DEF_FAIL_CODE      = 16'h7345;
    localparam int          DEF_STABLE_CYCLES  = 4;
    localparam int          DEF_TIMEOUT_CYCLES = 500000;
    localparam int          DEF_CNT_W          = 20;

endpackage

// File: rtl/checkbits_monitor_filter.sv
// Two-flop synchroniser plus stability filter for the asynchronous status bus.
// filt only takes a value after it has been sampled unchanged STABLE_CYCLES+1 times.
module checkbits_filter
    import checkbits_monitor_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] checkbits,
    output logic [WIDTH-1:0] filt,
    output logic             filt_chg
);

    localparam int                SCNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]  s1;
    logic [WIDTH-1:0]  s2;
    logic [WIDTH-1:0]  cand;
    logic [SCNT_W-1:0] scnt;

    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking here would let s1 ripple straight into s2 in one edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            cand     <= '0;
            scnt     <= '0;
            filt     <= '0;
            filt_chg <= 1'b0;
        end else begin
            s1       <= checkbits;
            s2       <= s1;
            filt_chg <= 1'b0;
            if (s2 != cand) begin
                cand <= s2;
                scnt <= '0;
            end else if (scnt != SCNT_LAST) begin
                scnt <= scnt + SCNT_W'(1);
            end else begin
                // Reloads every cycle while stable; strobe only on a real change.
                filt     <= cand;
                filt_chg <= (cand != filt);
            end
        end
    end

endmodule

// File: rtl/checkbits_monitor.sv
// Pass/fail monitor: filters the firmware status bus, tracks alive -> terminal code
// with a cycle timeout, and holds a sticky one-hot verdict until reset or enable drops.
module checkbits_monitor
    import checkbits_monitor_pkg::*;
#(
    parameter int               WIDTH          = DEF_WIDTH,
    parameter logic [WIDTH-1:0] ALIVE_CODE     = WIDTH'(DEF_ALIVE_CODE),
    parameter logic [WIDTH-1:0] PASS_CODE      = WIDTH'(DEF_PASS_CODE),
    parameter logic [WIDTH-1:0] FAIL_CODE      = WIDTH'(DEF_FAIL_CODE),
    parameter int               STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int               TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int               CNT_W          = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] checkbits,
    output logic             alive,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             unknown,
    output logic             timeout,
    output logic [WIDTH-1:0] result_code,
    output logic [CNT_W-1:0] cycles,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT_CYCLES);

    logic [WIDTH-1:0] filt;
    logic             filt_chg;

    state_t           state_q,   state_d;
    logic             alive_q,   alive_d;
    logic             done_q,    done_d;
    verdict_t         verdict_q, verdict_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [CNT_W-1:0] cycles_q,  cycles_d;

    logic [CNT_W-1:0] cycles_inc;
    logic             at_timeout;

    checkbits_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock     (clock),
        .reset     (reset),
        .checkbits (checkbits),
        .filt      (filt),
        .filt_chg  (filt_chg)
    );

    assign cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_W'(1);
    assign at_timeout = (cycles_q == TIMEOUT_LAST);

    // NOTE: every variable gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        alive_d   = alive_q;
        done_d    = done_q;
        verdict_d = verdict_q;
        result_d  = result_q;
        cycles_d  = cycles_q;

        if (!enable) begin
            state_d   = IDLE;
            alive_d   = 1'b0;
            done_d    = 1'b0;
            verdict_d = '0;
            result_d  = '0;
            cycles_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The enabling edge is counted, so cycles equals edges since enable.
                    state_d   = WAIT_ALIVE;
                    alive_d   = 1'b0;
                    done_d    = 1'b0;
                    verdict_d = '0;
                    result_d  = '0;
                    cycles_d  = CNT_W'(1);
                end
                WAIT_ALIVE: begin
                    cycles_d = cycles_inc;
                    if (at_timeout) begin
                        state_d           = DONE;
                        done_d            = 1'b1;
                        verdict_d.timeout = 1'b1;
                        result_d          = '0;
                        cycles_d          = TIMEOUT_CNT;
                    end else if (filt == ALIVE_CODE) begin
                        state_d = RUNNING;
                        alive_d = 1'b1;
                    end
                end
                RUNNING: begin
                    cycles_d = cycles_inc;
                    // A terminal code on the timeout edge still wins.
                    if (filt_chg && (filt != ALIVE_CODE)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        result_d  = filt;
                        verdict_d = '0;
                        if (filt == PASS_CODE)      verdict_d.pass    = 1'b1;
                        else if (filt == FAIL_CODE) verdict_d.fail    = 1'b1;
                        else                        verdict_d.unknown = 1'b1;
                    end else if (at_timeout) begin
                        state_d           = DONE;
                        done_d            = 1'b1;
                        verdict_d.timeout = 1'b1;
                        result_d          = '0;
                        cycles_d          = TIMEOUT_CNT;
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            alive_q   <= 1'b0;
            done_q    <= 1'b0;
            verdict_q <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= alive_d;
            done_q    <= done_d;
            verdict_q <= verdict_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
        end
    end

    assign alive       = alive_q;
    assign done        = done_q;
    assign pass        = verdict_q.pass;
    assign fail        = verdict_q.fail;
    assign unknown     = verdict_q.unknown;
    assign timeout     = verdict_q.timeout;
    assign result_code = result_q;
    assign cycles      = cycles_q;
    assign state       = state_q;

endmodule
